approx_mult_err_monitor: RTL
============================

# approx_mult_err_monitor

Sequential error-characterisation stage that sits directly downstream of the 8x8 approximate Dadda multiplier. It consumes operand pairs together with the multiplier's 16-bit approximate product. For each pair it computes the exact product and the absolute error distance (ED). Over a programmed batch of samples it accumulates the error statistics the team reports: error count, sum of ED and maximum ED with its operands.

## Interface
Parameters:
- W, 8, operand width; products are 2W bits
- CNT_W, 17, sample-counter width; a batch holds at most 2^CNT_W-1 samples, so 65536 fits
- SUM_W, 2W+CNT_W (33), width of the ED accumulator; it cannot overflow within a batch

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse that starts a batch; honoured only in IDLE
- num_samples  in  CNT_W  batch length, sampled on an accepted start
- in_valid  in  1  a, b and p_approx are valid this cycle
- in_ready  out  1  monitor accepts a sample this cycle
- a  in  W  operand A as applied to the multiplier
- b  in  W  operand B as applied to the multiplier
- p_approx  in  2W  multiplier output for (a, b)
- busy  out  1  high in RUN and DRAIN
- done  out  1  one-cycle pulse; statistics are final
- sample_count  out  CNT_W  samples accumulated so far
- err_count  out  CNT_W  samples with ED != 0
- sum_ed  out  SUM_W  sum of ED
- max_ed  out  2W  largest ED
- max_a  out  W  operand A of the first sample reaching max_ed
- max_b  out  W  operand B of the first sample reaching max_ed

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- IDLE: in_ready=0.
  - start with num_samples>0: clear all statistics, load remaining=num_samples, go to RUN.
  - start with num_samples=0: clear all statistics, go to DONE.
- RUN: in_ready=1 (combinational from state). A sample is accepted when in_valid & in_ready; remaining decrements. Accepting the last sample (remaining==1) moves to DRAIN.
- DRAIN: in_ready=0 for exactly 2 cycles while the pipeline empties, then go to DONE.
- DONE: done=1 for one cycle, then go to IDLE.
- start is ignored outside IDLE. in_valid outside RUN is ignored; no sample is accepted after the last one.
- Pipeline stages:
  - S1 registers a, b, p_approx and a valid bit.
  - S2 computes exact = a*b (2W bits) and ED = |exact - p_approx|, using a 2W+1-bit signed difference and a 2W-bit magnitude. It registers ED, a, b and a nz flag (ED != 0).
  - S3 accumulates: sample_count += 1, err_count += nz, sum_ed += ED. If ED > max_ed (strictly greater), it loads max_ed, max_a and max_b. Ties keep the earlier sample.
- Statistics hold their values after DONE until the next accepted start or rst.
- rst in any state: state=IDLE; all outputs and pipeline valids become 0; any partial batch is discarded.

## Timing
- Reset values: in_ready=0, busy=0, done=0, sample_count=0, err_count=0, sum_ed=0, max_ed=0, max_a=0, max_b=0.
- start accepted at edge of cycle s: busy=1 and in_ready=1 from cycle s+1.
- Sample accepted in cycle t: its contribution is visible on the statistics outputs from cycle t+3.
- Last sample accepted in cycle t: DRAIN during t+1 and t+2; done=1 and busy=0 in cycle t+3, with final statistics valid; IDLE from t+4.
- num_samples=0: start at s gives done=1 in cycle s+1 with all statistics 0.
- Throughput is one sample per cycle; gaps on in_valid are allowed with no loss.
- A start during DONE is ignored. A start in the first IDLE cycle after DONE is accepted.

## Test plan
- Exhaustive 65536 pairs, p_approx=a*b: done 3 cycles after the last accept; sample_count=65536, err_count=0, sum_ed=0, max_ed=0.
- Single sample a=255, b=255, p_approx=0xFE00 (exact 0xFE01): ED=1, err_count=1, sum_ed=1, max_ed=1, max_a=255, max_b=255.
- Three samples: (3,5,p=20) gives ED 5; (2,2,p=4) gives ED 0; (7,9,p=58) gives ED 5. Required: err_count=2, sum_ed=10, max_ed=5, max_a=3, max_b=5 (tie keeps the first).
- num_samples=4 with in_valid toggling 1,0,0,1,1,0,1,1,1: exactly 4 samples accepted; in_ready=0 from the cycle after the 4th accept; sample_count=4.
- num_samples=0: done=1 in cycle s+1, all statistics 0, busy never asserted. A start during RUN does not re-clear the statistics.
- rst asserted mid-RUN after 10 accepts: next cycle all outputs 0 and state IDLE. A new batch of 2 exact samples ends with sample_count=2 and err_count=0.

Source files
------------

// File: rtl/approx_mult_err_monitor.sv
// Error-characterisation stage for the 8x8 approximate multiplier: computes the
// exact product and error distance per sample and accumulates batch statistics.
module approx_mult_err_monitor #(
    parameter int W     = 8,
    parameter int CNT_W = 17,
    parameter int SUM_W = 2*W + CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] num_samples,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     a,
    input  logic [W-1:0]     b,
    input  logic [2*W-1:0]   p_approx,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] sample_count,
    output logic [CNT_W-1:0] err_count,
    output logic [SUM_W-1:0] sum_ed,
    output logic [2*W-1:0]   max_ed,
    output logic [W-1:0]     max_a,
    output logic [W-1:0]     max_b
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t             state_reg, state_next;
    logic [CNT_W-1:0]   remaining_reg, remaining_next;
    logic               drain_reg, drain_next;
    logic               clear_stats;
    logic               accept;

    logic               s1_valid_reg;
    logic [W-1:0]       s1_a_reg, s1_b_reg;
    logic [2*W-1:0]     s1_p_reg;

    logic               s2_valid_reg;
    logic [W-1:0]       s2_a_reg, s2_b_reg;
    logic [2*W-1:0]     s2_ed_reg;
    logic               s2_nz_reg;

    logic [CNT_W-1:0]   sample_count_reg, err_count_reg;
    logic [SUM_W-1:0]   sum_ed_reg;
    logic [2*W-1:0]     max_ed_reg;
    logic [W-1:0]       max_a_reg, max_b_reg;

    logic [2*W-1:0]     exact;
    logic [2*W:0]       diff;
    logic [2*W-1:0]     ed;

    assign in_ready = (state_reg == RUN);
    assign busy     = (state_reg == RUN) || (state_reg == DRAIN);
    assign done     = (state_reg == DONE);
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_next     = state_reg;
        remaining_next = remaining_reg;
        drain_next     = drain_reg;
        clear_stats    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    clear_stats = 1'b1;
                    if (num_samples != '0) begin
                        remaining_next = num_samples;
                        state_next     = RUN;
                    end else begin
                        state_next = DONE;
                    end
                end
            end
            RUN: begin
                if (in_valid) begin
                    remaining_next = remaining_reg - CNT_W'(1);
                    if (remaining_reg == CNT_W'(1)) begin
                        state_next = DRAIN;
                        drain_next = 1'b0;
                    end
                end
            end
            DRAIN: begin
                // Two cycles: lets the last sample clear S2 and land in S3.
                if (drain_reg) state_next = DONE;
                else           drain_next = 1'b1;
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            remaining_reg <= '0;
            drain_reg     <= 1'b0;
        end else begin
            state_reg     <= state_next;
            remaining_reg <= remaining_next;
            drain_reg     <= drain_next;
        end
    end

    // Sign of the widened difference selects which way to subtract.
    assign exact = (2*W)'(s1_a_reg) * (2*W)'(s1_b_reg);
    assign diff  = {1'b0, exact} - {1'b0, s1_p_reg};
    assign ed    = diff[2*W] ? (s1_p_reg - exact) : diff[2*W-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_reg     <= 1'b0;
            s1_a_reg         <= '0;
            s1_b_reg         <= '0;
            s1_p_reg         <= '0;
            s2_valid_reg     <= 1'b0;
            s2_a_reg         <= '0;
            s2_b_reg         <= '0;
            s2_ed_reg        <= '0;
            s2_nz_reg        <= 1'b0;
            sample_count_reg <= '0;
            err_count_reg    <= '0;
            sum_ed_reg       <= '0;
            max_ed_reg       <= '0;
            max_a_reg        <= '0;
            max_b_reg        <= '0;
        end else begin
            s1_valid_reg <= accept;
            if (accept) begin
                s1_a_reg <= a;
                s1_b_reg <= b;
                s1_p_reg <= p_approx;
            end
            s2_valid_reg <= s1_valid_reg;
            if (s1_valid_reg) begin
                s2_a_reg  <= s1_a_reg;
                s2_b_reg  <= s1_b_reg;
                s2_ed_reg <= ed;
                s2_nz_reg <= (ed != '0);
            end
            if (clear_stats) begin
                sample_count_reg <= '0;
                err_count_reg    <= '0;
                sum_ed_reg       <= '0;
                max_ed_reg       <= '0;
                max_a_reg        <= '0;
                max_b_reg        <= '0;
            end else if (s2_valid_reg) begin
                sample_count_reg <= sample_count_reg + CNT_W'(1);
                err_count_reg    <= err_count_reg + CNT_W'(s2_nz_reg);
                sum_ed_reg       <= sum_ed_reg + SUM_W'(s2_ed_reg);
                // Strictly greater: ties keep the earlier sample's operands.
                if (s2_ed_reg > max_ed_reg) begin
                    max_ed_reg <= s2_ed_reg;
                    max_a_reg  <= s2_a_reg;
                    max_b_reg  <= s2_b_reg;
                end
            end
        end
    end

    assign sample_count = sample_count_reg;
    assign err_count    = err_count_reg;
    assign sum_ed       = sum_ed_reg;
    assign max_ed       = max_ed_reg;
    assign max_a        = max_a_reg;
    assign max_b        = max_b_reg;

endmodule
